// File: rtl/xorpuf_challenge_driver.sv
// XOR PUF challenge sequencer: expands one master challenge into K arbiter challenges,
// launches the arbiter chains, samples the XOR response and majority-votes over REPS runs.
// Optional build macro: XORPUF_CHAL_ROTATE_EN (slice j rotated left by j*ROT bits).
module xorpuf_challenge_driver #(
  parameter int unsigned K      = 10,
  parameter int unsigned M      = K - 1,
  parameter int unsigned N      = 64,
  parameter int unsigned ROT    = 1,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned EVAL   = 8,
  parameter int unsigned REPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     chal_in,
  input  logic             chal_valid,
  output logic             chal_ready,
  output logic [K*N-1:0]   puf_chal,
  output logic             puf_launch,
  input  logic [M-1:0]     puf_rsp,
  output logic [M-1:0]     rsp_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int unsigned CNT_MAX = (SETTLE > EVAL) ? SETTLE : EVAL;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned RW      = $clog2(REPS + 1);
`ifdef XORPUF_CHAL_ROTATE_EN
  localparam int unsigned ROT_STEP = ROT % N;
`else
  // rotation compiled out: every slice is the unrotated master challenge
  localparam int unsigned ROT_STEP = ROT * 0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_LAUNCH,
    S_EVAL,
    S_SAMPLE,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [RW-1:0]    r_rep;
  logic [RW-1:0]    w_rep_nxt;
  logic [RW-1:0]    r_ones     [M];
  logic [RW-1:0]    w_ones_nxt [M];
  logic [RW-1:0]    w_ones_sum [M];
  logic [M-1:0]     w_vote;
  logic [K*N-1:0]   r_chal;
  logic [K*N-1:0]   w_chal_nxt;
  logic [K*N-1:0]   w_chal_exp;
  logic [2*N-1:0]   w_dbl;
  logic [M-1:0]     r_rsp;
  logic [M-1:0]     w_rsp_nxt;
  logic             r_chal_ready;
  logic             r_busy;
  logic             r_launch;
  logic             r_rsp_valid;

  // Rotate-left by SH is the N-bit window of {x,x} starting at bit N-SH.
  assign w_dbl = {chal_in, chal_in};

  for (genvar j = 0; j < K; j++) begin : g_slice
    localparam int unsigned SH = (j * ROT_STEP) % N;
    assign w_chal_exp[j*N +: N] = w_dbl[N-SH +: N];
  end

  always_comb begin
    for (int unsigned i = 0; i < M; i++) begin
      w_ones_sum[i] = r_ones[i] + RW'(puf_rsp[i]);
      w_vote[i]     = (w_ones_sum[i] > RW'(REPS / 2));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rep_nxt   = r_rep;
    w_ones_nxt  = r_ones;
    w_chal_nxt  = r_chal;
    w_rsp_nxt   = r_rsp;
    case (r_state)
      S_IDLE: begin
        if (chal_valid && r_chal_ready) begin
          w_chal_nxt  = w_chal_exp;
          w_cnt_nxt   = '0;
          w_rep_nxt   = '0;
          for (int unsigned i = 0; i < M; i++) w_ones_nxt[i] = '0;
          w_state_nxt = S_APPLY;
        end
      end
      S_APPLY: begin
        if (r_cnt == CW'(SETTLE - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_LAUNCH;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (r_cnt == CW'(EVAL - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_SAMPLE: begin
        w_ones_nxt = w_ones_sum;
        w_rep_nxt  = r_rep + RW'(1);
        if (w_rep_nxt == RW'(REPS)) begin
          w_rsp_nxt   = w_vote;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_APPLY;
        end
      end
      S_HOLD: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake/launch outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rep        <= '0;
      for (int unsigned i = 0; i < M; i++) r_ones[i] <= '0;
      r_chal       <= '0;
      r_rsp        <= '0;
      r_chal_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_launch     <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rep        <= w_rep_nxt;
      for (int unsigned i = 0; i < M; i++) r_ones[i] <= w_ones_nxt[i];
      r_chal       <= w_chal_nxt;
      r_rsp        <= w_rsp_nxt;
      r_chal_ready <= (w_state_nxt == S_IDLE);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_launch     <= (w_state_nxt == S_LAUNCH);
      r_rsp_valid  <= (w_state_nxt == S_HOLD);
    end
  end

  assign chal_ready = r_chal_ready;
  assign busy       = r_busy;
  assign puf_launch = r_launch;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_out    = r_rsp;
  assign puf_chal   = r_chal;

endmodule

// File: tb/tb_xorpuf_challenge_driver.sv
// Directed bench for xorpuf_challenge_driver: one REPS=1 instance and one REPS=3 instance.
// Slice expectations follow XORPUF_CHAL_ROTATE_EN when the bench is built with it.
module tb_xorpuf_challenge_driver;

  localparam int unsigned K = 10;
  localparam int unsigned N = 64;
  localparam int unsigned M = 9;

  logic           clk = 1'b0;
  logic           rst_n;

  logic [N-1:0]   a_chal_in,  b_chal_in;
  logic           a_chal_valid, b_chal_valid;
  logic           a_chal_ready, b_chal_ready;
  logic [K*N-1:0] a_puf_chal, b_puf_chal;
  logic           a_launch,   b_launch;
  logic [M-1:0]   a_puf_rsp,  b_puf_rsp;
  logic [M-1:0]   a_rsp_out,  b_rsp_out;
  logic           a_rsp_valid, b_rsp_valid;
  logic           a_rsp_ready, b_rsp_ready;
  logic           a_busy,     b_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xorpuf_challenge_driver #(.K(K), .M(M), .N(N), .ROT(1), .SETTLE(4), .EVAL(8), .REPS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .chal_in(a_chal_in), .chal_valid(a_chal_valid),
    .chal_ready(a_chal_ready), .puf_chal(a_puf_chal), .puf_launch(a_launch),
    .puf_rsp(a_puf_rsp), .rsp_out(a_rsp_out), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .busy(a_busy)
  );

  xorpuf_challenge_driver #(.K(K), .M(M), .N(N), .ROT(1), .SETTLE(4), .EVAL(8), .REPS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .chal_in(b_chal_in), .chal_valid(b_chal_valid),
    .chal_ready(b_chal_ready), .puf_chal(b_puf_chal), .puf_launch(b_launch),
    .puf_rsp(b_puf_rsp), .rsp_out(b_rsp_out), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_slice(input logic [63:0] c, input int j);
`ifdef XORPUF_CHAL_ROTATE_EN
    int sh;
    sh = j % 64;
    if (sh == 0) return c;
    return (c << sh) | (c >> (64 - sh));
`else
    if (j < 0) return '0;
    return c;
`endif
  endfunction

  // Accept chal on instance A, supply rsp only in cycle T0+14, and record timing for 20 cycles.
  task automatic run_a(input logic [63:0] chal, input logic [M-1:0] rsp, input bit noise,
                       output int lc, output int lk, output int rk, output logic [M-1:0] ro);
    a_chal_in    = chal;
    a_chal_valid = 1'b1;
    tick();
    a_chal_valid = 1'b0;
    lc = 0; lk = 0; rk = 0; ro = '0;
    for (int k = 1; k <= 20; k++) begin
      if (a_launch) begin
        lc++;
        if (lk == 0) lk = k;
      end
      if (a_rsp_valid && rk == 0) begin
        rk = k;
        ro = a_rsp_out;
      end
      a_puf_rsp = (k == 14) ? rsp : 9'h000;
      if (noise) begin
        a_chal_valid = (k >= 2 && k < 12);
        a_chal_in    = 64'hDEAD_BEEF_CAFE_F00D;
      end
      tick();
    end
    a_chal_valid = 1'b0;
  endtask

  initial begin
    int lc, lk, rk;
    int n_launch, n_drop, n_busy, n_unstable, n_ready, n_lost, n_rv;
    int b_lk [3];
    logic [M-1:0] ro;

    rst_n = 1'b0;
    a_chal_in = '0; a_chal_valid = 1'b0; a_puf_rsp = '0; a_rsp_ready = 1'b0;
    b_chal_in = '0; b_chal_valid = 1'b0; b_puf_rsp = '0; b_rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_chal_ready", 64'(a_chal_ready), 64'd1);
    chk("rst_busy",       64'(a_busy),       64'd0);
    chk("rst_rsp_valid",  64'(a_rsp_valid),  64'd0);
    chk("rst_launch",     64'(a_launch),     64'd0);
    chk("rst_rsp_out",    64'(a_rsp_out),    64'd0);
    chk("rst_puf_chal",   a_puf_chal[9*N +: N], 64'd0);
    chk("rst_b_ready",    64'(b_chal_ready), 64'd1);
    rst_n = 1'b1;

    // Idle for 50 cycles: nothing may launch or drop ready.
    n_launch = 0; n_drop = 0; n_busy = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (a_launch || b_launch) n_launch++;
      if (!a_chal_ready || !b_chal_ready) n_drop++;
      if (a_busy || b_busy || a_rsp_valid || b_rsp_valid) n_busy++;
    end
    chk("idle_launch", 64'(n_launch), 64'd0);
    chk("idle_ready",  64'(n_drop),   64'd0);
    chk("idle_busy",   64'(n_busy),   64'd0);

    // REPS=1 challenge with ignored chal_valid noise while busy.
    run_a(64'h1, 9'h1A5, 1'b1, lc, lk, rk, ro);
    chk("a1_launch_cnt", 64'(lc), 64'd1);
    chk("a1_launch_cyc", 64'(lk), 64'd5);
    chk("a1_valid_cyc",  64'(rk), 64'd15);
    chk("a1_rsp_out",    64'(ro), 64'h1A5);
    chk("a1_slice0", a_puf_chal[0*N +: N], exp_slice(64'h1, 0));
    chk("a1_slice1", a_puf_chal[1*N +: N], exp_slice(64'h1, 1));
    chk("a1_slice9", a_puf_chal[9*N +: N], exp_slice(64'h1, 9));
    chk("a1_hold_ready", 64'(a_chal_ready), 64'd0);
    chk("a1_hold_busy",  64'(a_busy),       64'd1);

    // Back-pressure: 20 cycles of rsp_ready=0 with a pending challenge.
    a_chal_in = 64'h3; a_chal_valid = 1'b1; a_rsp_ready = 1'b0;
    n_unstable = 0; n_ready = 0; n_lost = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_rsp_out !== 9'h1A5) n_unstable++;
      if (a_chal_ready) n_ready++;
      if (!a_rsp_valid) n_lost++;
    end
    chk("bp_rsp_stable", 64'(n_unstable), 64'd0);
    chk("bp_chal_ready", 64'(n_ready),    64'd0);
    chk("bp_rsp_valid",  64'(n_lost),     64'd0);
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    chk("hs_rsp_valid",  64'(a_rsp_valid),  64'd0);
    chk("hs_chal_ready", 64'(a_chal_ready), 64'd1);
    chk("hs_not_taken",  a_puf_chal[0*N +: N], exp_slice(64'h1, 0));
    tick();
    a_chal_valid = 1'b0;
    chk("acc2_busy",   64'(a_busy), 64'd1);
    chk("acc2_slice0", a_puf_chal[0*N +: N], exp_slice(64'h3, 0));
    chk("acc2_slice1", a_puf_chal[1*N +: N], exp_slice(64'h3, 1));

    // Reset in the middle of EVAL (cycle T0+8).
    repeat (7) tick();
    chk("eval_busy", 64'(a_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",  64'(a_chal_ready), 64'd1);
    chk("mid_rst_busy",   64'(a_busy),       64'd0);
    chk("mid_rst_launch", 64'(a_launch),     64'd0);
    chk("mid_rst_chal",   a_puf_chal[0*N +: N], 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    n_rv = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (a_rsp_valid || a_launch) n_rv++;
    end
    chk("post_rst_quiet", 64'(n_rv),          64'd0);
    chk("post_rst_ready", 64'(a_chal_ready),  64'd1);
    chk("post_rst_chal",  a_puf_chal[0*N +: N], 64'd0);

    run_a(64'h5, 9'h155, 1'b0, lc, lk, rk, ro);
    chk("a2_launch_cnt", 64'(lc), 64'd1);
    chk("a2_launch_cyc", 64'(lk), 64'd5);
    chk("a2_valid_cyc",  64'(rk), 64'd15);
    chk("a2_rsp_out",    64'(ro), 64'h155);
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    chk("a2_done", 64'(a_rsp_valid), 64'd0);

    // REPS=3 majority vote; off-sample cycles drive all-ones to expose mistimed sampling.
    b_chal_in = 64'hF0; b_chal_valid = 1'b1;
    tick();
    b_chal_valid = 1'b0;
    lc = 0; rk = 0; ro = '0;
    b_lk[0] = 0; b_lk[1] = 0; b_lk[2] = 0;
    for (int k = 1; k <= 50; k++) begin
      if (b_launch) begin
        if (lc < 3) b_lk[lc] = k;
        lc++;
      end
      if (b_rsp_valid && rk == 0) begin
        rk = k;
        ro = b_rsp_out;
      end
      b_puf_rsp = (k == 14) ? 9'h0FF : (k == 28) ? 9'h1F0 : (k == 42) ? 9'h00F : 9'h1FF;
      tick();
    end
    chk("b_launch_cnt", 64'(lc),      64'd3);
    chk("b_launch_1",   64'(b_lk[0]), 64'd5);
    chk("b_launch_2",   64'(b_lk[1]), 64'd19);
    chk("b_launch_3",   64'(b_lk[2]), 64'd33);
    chk("b_valid_cyc",  64'(rk),      64'd43);
    chk("b_rsp_out",    64'(ro),      64'h0FF);
    chk("b_slice9",     b_puf_chal[9*N +: N], exp_slice(64'hF0, 9));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
